// File: rtl/reg_arb.sv
// Purpose    : round-robin arbiter sharing one register bus between two masters.
// Latency    : req seen in IDLE at cycle N -> r_valid at N+1 -> mX_ack at N+2 -> IDLE at N+3.
// Backpressure: one transaction in flight; a losing or late master holds req until its ack.
//
// Ports
//   clk, reset            : clock and synchronous active-high reset
//   m0_* / m1_*           : master request channels (req/wen/addr/wdata in, ack/rdata out)
//   r_valid/r_wen/r_addr/r_wdata/r_rdata : shared register-file bus
//   busy                  : high whenever the FSM is not in IDLE
module reg_arb #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_wen,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_wen,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              r_valid,
    output logic              r_wen,
    output logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_wdata,
    input  logic [DATA_W-1:0] r_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic prio;    // preferred master when both request (0 = m0)
    logic gnt;     // master owning the in-flight transaction
    logic sel;     // master chosen in the current IDLE cycle
    logic any_req;

    assign any_req = m0_req | m1_req;
    // Contention goes to the preferred master; a lone requester always wins.
    assign sel     = (m0_req && m1_req) ? prio : m1_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_valid   = 1'b0;
        busy      = 1'b1;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                r_valid   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                // Reset during DONE drops the transaction, so the ack is masked.
                m0_ack    = !gnt && !reset;
                m1_ack    =  gnt && !reset;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant capture, priority rotation and read-data return. Bus fields are
    // only loaded on a grant, so they hold their values while r_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio     <= 1'b0;
            gnt      <= 1'b0;
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                gnt     <= sel;
                prio    <= ~sel;
                r_wen   <= sel ? m1_wen   : m0_wen;
                r_addr  <= sel ? m1_addr  : m0_addr;
                r_wdata <= sel ? m1_wdata : m0_wdata;
            end
            if (state == ISSUE && !r_wen) begin
                if (gnt) begin
                    m1_rdata <= r_rdata;
                end else begin
                    m0_rdata <= r_rdata;
                end
            end
        end
    end

endmodule
